ttc_frame_tx: RTL

TTC_FRAME_TX -- requirements
Module: ttc_frame_tx

---
 rtl/ttc_pkg.sv | 9 +
 rtl/ttc_frame_tx.sv | 108 ++++++++++
 2 files changed

// File: rtl/ttc_pkg.sv
// Constants and state type shared by the TTC frame transmitter and receiver.
package ttc_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam logic [FRAME_BITS-1:0] SYNC_WORD_DEFAULT = 16'h817E;

    typedef enum logic {SYNC, RUN} ttc_state_e;

endpackage

// File: rtl/ttc_frame_tx.sv
// Serial TTC frame transmitter: sends SYNC_WORD frames until the link is aligned, then user words
// through a one-entry holding register, with SYNC_WORD as the idle fill.
module ttc_frame_tx
    import ttc_pkg::*;
#(
    parameter logic [FRAME_BITS-1:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
    parameter int unsigned           SYNC_REPEAT = 16
) (
    input  logic                  clk160,
    input  logic                  rst,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  resync,
    output logic                  dataout,
    output logic                  frame_start,
    output logic                  sync_done,
    output logic                  data_frame
);

    localparam int unsigned CW = $clog2(SYNC_REPEAT + 1);
    localparam int unsigned BW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] SYNC_MAX = CW'(SYNC_REPEAT);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    ttc_state_e            state;
    logic [BW-1:0]         bit_cnt;
    logic [CW-1:0]         sync_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic [FRAME_BITS-1:0] hold;
    logic                  hold_full;
    logic                  shift_is_data;
    logic                  resync_pend;

    logic                  accept;
    logic                  boundary;
    logic                  do_resync;
    logic                  enter_run;
    logic                  bypass;
    logic [CW-1:0]         sync_cnt_inc;

    assign tx_ready     = !hold_full && !rst;
    assign accept       = tx_valid && tx_ready;
    assign boundary     = (bit_cnt == LAST_BIT);
    // A request arriving in the boundary cycle itself takes effect at that boundary.
    assign do_resync    = resync_pend || resync;
    assign sync_cnt_inc = (sync_cnt == SYNC_MAX) ? sync_cnt : sync_cnt + 1'b1;
    assign enter_run    = !do_resync && ((state == RUN) || (sync_cnt_inc == SYNC_MAX));
    assign bypass       = boundary && enter_run && accept;

    always_ff @(posedge clk160) begin
        if (rst) begin
            state         <= SYNC;
            bit_cnt       <= '0;
            sync_cnt      <= '0;
            shift         <= SYNC_WORD;
            hold          <= '0;
            hold_full     <= 1'b0;
            shift_is_data <= 1'b0;
            resync_pend   <= 1'b0;
            dataout       <= 1'b0;
            frame_start   <= 1'b0;
            sync_done     <= 1'b0;
            data_frame    <= 1'b0;
        end else begin
            dataout     <= shift[FRAME_BITS-1];
            frame_start <= (bit_cnt == '0);
            data_frame  <= shift_is_data;
            sync_done   <= (state == RUN);
            // FRAME_BITS is a power of two, so the counter wraps 15 -> 0 naturally.
            bit_cnt     <= bit_cnt + 1'b1;

            if (accept && !bypass) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end

            if (!boundary) begin
                shift <= {shift[FRAME_BITS-2:0], shift[FRAME_BITS-1]};
                if (resync) begin
                    resync_pend <= 1'b1;
                end
            end else begin
                resync_pend   <= 1'b0;
                shift         <= SYNC_WORD;
                shift_is_data <= 1'b0;
                if (do_resync) begin
                    state    <= SYNC;
                    sync_cnt <= '0;
                end else begin
                    sync_cnt <= sync_cnt_inc;
                    if (enter_run) begin
                        state <= RUN;
                        if (hold_full) begin
                            shift         <= hold;
                            shift_is_data <= 1'b1;
                            hold_full     <= 1'b0;
                        end else if (accept) begin
                            shift         <= tx_data;
                            shift_is_data <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
